// File: rtl/flex_updown_counter.sv
// Up/down counter with run-time rollover value, sync load, terminal-count flag,
// wrap pulse and wrap-event counter. Define FLEX_CNT_SATURATE_EN to saturate at T.
module flex_updown_counter #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     count_enable,
    input  logic                     count_up,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     rollover_pulse,
    output logic [NUM_WRAP_BITS-1:0] wrap_count
);

    localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_ONE = NUM_WRAP_BITS'(1);

    logic [NUM_CNT_BITS-1:0]  terminal;
    logic [NUM_CNT_BITS-1:0]  step_cnt;
    logic                     step_event;
    logic [NUM_CNT_BITS-1:0]  count_nxt;
    logic                     flag_nxt;
    logic                     pulse_nxt;
    logic [NUM_WRAP_BITS-1:0] wrap_nxt;

    assign terminal = count_up ? rollover_val : CNT_ONE;

    // Result of one enabled step; step_event marks a wrap (or arrival at T when saturating)
    always_comb begin
        step_cnt   = count_out;
        step_event = 1'b0;
`ifdef FLEX_CNT_SATURATE_EN
        if (count_up) begin
            if (count_out >= rollover_val) begin
                step_cnt = rollover_val;
            end else begin
                step_cnt = count_out + CNT_ONE;
            end
        end else begin
            if (count_out <= CNT_ONE) begin
                step_cnt = CNT_ONE;
            end else begin
                step_cnt = count_out - CNT_ONE;
            end
        end
        step_event = (step_cnt == terminal) && (count_out != terminal);
`else
        if (count_up) begin
            if (count_out >= rollover_val) begin
                step_cnt   = CNT_ONE;
                step_event = 1'b1;
            end else begin
                step_cnt = count_out + CNT_ONE;
            end
        end else begin
            if (count_out <= CNT_ONE) begin
                step_cnt   = rollover_val;
                step_event = 1'b1;
            end else begin
                step_cnt = count_out - CNT_ONE;
            end
        end
`endif
    end

    always_comb begin
        count_nxt = count_out;
        flag_nxt  = rollover_flag;
        pulse_nxt = 1'b0;
        wrap_nxt  = wrap_count;
        if (clear) begin
            count_nxt = '0;
            flag_nxt  = 1'b0;
            wrap_nxt  = '0;
        end else if (load) begin
            count_nxt = load_val;
            flag_nxt  = (load_val == terminal);
        end else if (count_enable && (rollover_val != '0)) begin
            count_nxt = step_cnt;
            flag_nxt  = (step_cnt == terminal);
            if (step_event) begin
                pulse_nxt = 1'b1;
                wrap_nxt  = wrap_count + WRAP_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            wrap_count     <= '0;
        end else begin
            count_out      <= count_nxt;
            rollover_flag  <= flag_nxt;
            rollover_pulse <= pulse_nxt;
            wrap_count     <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed bench for flex_updown_counter; a second instance uses a 2-bit wrap counter.
module tb_flex_updown_counter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear, load, count_enable, count_up;
    logic [3:0] load_val, rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag, rollover_pulse;
    logic [7:0] wrap_count;

    logic       clear_b, load_b, count_enable_b, count_up_b;
    logic [3:0] load_val_b, rollover_val_b;
    logic [3:0] count_out_b;
    logic       rollover_flag_b, rollover_pulse_b;
    logic [1:0] wrap_count_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    flex_updown_counter #(.NUM_CNT_BITS(4), .NUM_WRAP_BITS(8)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
        .count_enable(count_enable), .count_up(count_up),
        .load_val(load_val), .rollover_val(rollover_val),
        .count_out(count_out), .rollover_flag(rollover_flag),
        .rollover_pulse(rollover_pulse), .wrap_count(wrap_count)
    );

    flex_updown_counter #(.NUM_CNT_BITS(4), .NUM_WRAP_BITS(2)) dut_w2 (
        .clk(clk), .n_rst(n_rst), .clear(clear_b), .load(load_b),
        .count_enable(count_enable_b), .count_up(count_up_b),
        .load_val(load_val_b), .rollover_val(rollover_val_b),
        .count_out(count_out_b), .rollover_flag(rollover_flag_b),
        .rollover_pulse(rollover_pulse_b), .wrap_count(wrap_count_b)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt1[7]   = '{1, 2, 3, 4, 5, 1, 2};
        int exp_flag1[7]  = '{0, 0, 0, 0, 1, 0, 0};
        int exp_pulse1[7] = '{0, 0, 0, 0, 0, 1, 0};
        int exp_cnt2[4]   = '{2, 1, 5, 4};
        int exp_flag2[4]  = '{0, 1, 0, 0};
        int exp_pulse2[4] = '{0, 0, 1, 0};
        int exp_wrap5[5]  = '{1, 2, 3, 0, 1};
        int exp_cnts[5]   = '{1, 2, 3, 3, 3};
        int exp_flags[5]  = '{0, 0, 1, 1, 1};
        int exp_pulses[5] = '{0, 0, 1, 0, 0};

        n_rst = 1'b0;
        clear = 0; load = 0; count_enable = 0; count_up = 1;
        load_val = 0; rollover_val = 0;
        clear_b = 0; load_b = 0; count_enable_b = 0; count_up_b = 1;
        load_val_b = 0; rollover_val_b = 0;
        #12;
        check_val("rst_count", int'(count_out), 0);
        check_val("rst_flag", int'(rollover_flag), 0);
        check_val("rst_pulse", int'(rollover_pulse), 0);
        check_val("rst_wrap", int'(wrap_count), 0);
        n_rst = 1'b1;

`ifdef FLEX_CNT_SATURATE_EN
        rollover_val = 4'd3; count_up = 1; count_enable = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("sat_cnt%0d", i), int'(count_out), exp_cnts[i]);
            check_val($sformatf("sat_flag%0d", i), int'(rollover_flag), exp_flags[i]);
            check_val($sformatf("sat_pulse%0d", i), int'(rollover_pulse), exp_pulses[i]);
        end
        check_val("sat_wrap", int'(wrap_count), 1);
        count_up = 0;
        tick();
        check_val("sat_leave_down", int'(count_out), 2);
        count_enable = 0;
`else
        // 0 -> 5 then wrap to 1
        rollover_val = 4'd5; count_up = 1; count_enable = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_val($sformatf("up_cnt%0d", i), int'(count_out), exp_cnt1[i]);
            check_val($sformatf("up_flag%0d", i), int'(rollover_flag), exp_flag1[i]);
            check_val($sformatf("up_pulse%0d", i), int'(rollover_pulse), exp_pulse1[i]);
        end
        check_val("up_wrap", int'(wrap_count), 1);
        count_enable = 0;
        tick();
        check_val("hold_cnt", int'(count_out), 2);
        check_val("hold_pulse", int'(rollover_pulse), 0);

        load_val = 4'd3; load = 1; count_up = 0;
        tick();
        check_val("load_cnt", int'(count_out), 3);
        check_val("load_flag", int'(rollover_flag), 0);
        check_val("load_wrap", int'(wrap_count), 1);
        load = 0; count_enable = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("dn_cnt%0d", i), int'(count_out), exp_cnt2[i]);
            check_val($sformatf("dn_flag%0d", i), int'(rollover_flag), exp_flag2[i]);
            check_val($sformatf("dn_pulse%0d", i), int'(rollover_pulse), exp_pulse2[i]);
        end
        check_val("dn_wrap", int'(wrap_count), 2);

        count_up = 1;
        tick();
        check_val("dir_cnt", int'(count_out), 5);
        check_val("dir_flag", int'(rollover_flag), 1);

        // count above a lowered rollover wraps to 1
        count_enable = 0; load = 1; load_val = 4'd7;
        tick();
        load = 0; count_enable = 1;
        tick();
        check_val("over_cnt", int'(count_out), 1);
        check_val("over_pulse", int'(rollover_pulse), 1);
        check_val("over_wrap", int'(wrap_count), 3);
        count_enable = 0;
`endif

        load = 1; load_val = 4'd4;
        tick();
        check_val("pre_clr_cnt", int'(count_out), 4);
        clear = 1; load = 1; count_enable = 1;
        tick();
        check_val("clr_cnt", int'(count_out), 0);
        check_val("clr_flag", int'(rollover_flag), 0);
        check_val("clr_wrap", int'(wrap_count), 0);

        clear = 0; load = 0; rollover_val = 4'd0; count_enable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("r0_cnt%0d", i), int'(count_out), 0);
            check_val($sformatf("r0_pulse%0d", i), int'(rollover_pulse), 0);
        end
        count_enable = 0;

`ifndef FLEX_CNT_SATURATE_EN
        rollover_val_b = 4'd1; count_up_b = 1; load_val_b = 4'd1; load_b = 1;
        tick();
        load_b = 0; count_enable_b = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("w2_wrap%0d", i), int'(wrap_count_b), exp_wrap5[i]);
            check_val($sformatf("w2_cnt%0d", i), int'(count_out_b), 1);
        end
        count_enable_b = 0;
`endif

        // async reset in the middle of a cycle
        rollover_val = 4'd5; count_up = 1; count_enable = 1;
        tick();
        tick();
        check_val("pre_rst_cnt", int'(count_out), 2);
        #2;
        n_rst = 1'b0;
        #1;
        check_val("arst_cnt", int'(count_out), 0);
        check_val("arst_flag", int'(rollover_flag), 0);
        check_val("arst_pulse", int'(rollover_pulse), 0);
        check_val("arst_wrap", int'(wrap_count), 0);
        check_val("arst_wrap_b", int'(wrap_count_b), 0);
        check_val("arst_cnt_b", int'(count_out_b), 0);
        count_enable = 0;
        #10;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
